// File: rtl/fp16_adder_arbiter.sv
// fp16_adder_arbiter: round-robin sharing of one combinational fp16 adder
// among NREQ requesters, with an operand stage (s1), a result stage (s2) and
// a tagged valid/ready response channel that supports backpressure.

// fpadder: combinational fp16 a +/- b, round-to-nearest-even.
// Exact-zero results are returned as +0, and any NaN or invalid operation
// (inf - inf) returns the canonical 0xFE00.
module fpadder (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        sub,
   output logic [15:0] s
);
   logic [15:0] bx, big, sml;
   logic        a_nan, b_nan, a_inf, b_inf, rup;
   logic [6:0]  eb, es, dexp, er;
   logic [13:0] mb, ms_full, ms, norm;
   logic [14:0] sum;
   logic [11:0] rnd;

   // align, add/subtract magnitudes, normalize, round, then pack
   always_comb begin
      bx    = {b[15] ^ sub, b[14:0]};
      a_nan = (&a[14:10]) & (|a[9:0]);
      b_nan = (&bx[14:10]) & (|bx[9:0]);
      a_inf = (&a[14:10]) & ~(|a[9:0]);
      b_inf = (&bx[14:10]) & ~(|bx[9:0]);
      // order by magnitude so the difference never goes negative
      if (a[14:0] >= bx[14:0]) begin
         big = a;
         sml = bx;
      end else begin
         big = bx;
         sml = a;
      end
      // subnormals use exponent 1 with no hidden bit
      eb      = (big[14:10] == 5'd0) ? 7'd1 : {2'b00, big[14:10]};
      es      = (sml[14:10] == 5'd0) ? 7'd1 : {2'b00, sml[14:10]};
      mb      = {|big[14:10], big[9:0], 3'b000};
      ms_full = {|sml[14:10], sml[9:0], 3'b000};
      dexp    = eb - es;
      // three extra low bits carry guard, round and a sticky OR of the rest
      if (dexp >= 7'd14)
         ms = {13'd0, |ms_full};
      else
         ms = (ms_full >> dexp) | {13'd0, |(ms_full & ((14'd1 << dexp) - 14'd1))};
      if (big[15] ^ sml[15])
         sum = {1'b0, mb} - {1'b0, ms};
      else
         sum = {1'b0, mb} + {1'b0, ms};
      er = eb;
      if (sum[14]) begin
         norm = {sum[14:2], sum[1] | sum[0]};
         er   = eb + 7'd1;
      end else begin
         norm = sum[13:0];
         // stop at exponent 1 so tiny results fall into the subnormal range
         for (int i = 0; i < 13; i++) begin
            if (!norm[13] && er > 7'd1) begin
               norm = {norm[12:0], 1'b0};
               er   = er - 7'd1;
            end
         end
      end
      rup = norm[2] & (norm[1] | norm[0] | norm[3]);
      rnd = {1'b0, norm[13:3]} + {11'd0, rup};
      if (rnd[11]) begin
         rnd = {1'b0, rnd[11:1]};
         er  = er + 7'd1;
      end
      if (a_nan | b_nan | (a_inf & b_inf & (a[15] ^ bx[15])))
         s = 16'hFE00;
      else if (a_inf)
         s = a;
      else if (b_inf)
         s = bx;
      else if (sum == 15'd0)
         s = 16'h0000;
      else if (er >= 7'd31)
         s = {big[15], 5'h1F, 10'h000};
      else
         s = {big[15], rnd[10] ? er[4:0] : 5'd0, rnd[9:0]};
   end
endmodule

module fp16_adder_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2,
   parameter int CNTW = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req_valid,
   output logic [NREQ-1:0]    req_ready,
   input  logic [NREQ*16-1:0] req_a,
   input  logic [NREQ*16-1:0] req_b,
   input  logic [NREQ-1:0]    req_sub,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [IDW-1:0]     rsp_id,
   output logic [15:0]        rsp_sum,
   output logic               busy,
   output logic [CNTW-1:0]    op_count
);
   logic            s1_valid, s1_sub, s2_valid;
   logic [15:0]     s1_a, s1_b, s2_sum, add_s;
   logic [IDW-1:0]  s1_id, s2_id, rr_ptr, grant;
   logic            s1_en, s2_en, found, accept;
   int              idx;

   fpadder u_add (.a(s1_a), .b(s1_b), .sub(s1_sub), .s(add_s));

   // s2 advances when empty or drained; s1 advances when empty or s2 moves
   always_comb begin
      s2_en = !s2_valid | rsp_ready;
      s1_en = !s1_valid | s2_en;
   end

   // round-robin grant: first valid requester scanning from rr_ptr upward
   always_comb begin
      grant     = '0;
      found     = 1'b0;
      req_ready = '0;
      idx       = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(rr_ptr) + k) % NREQ;
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            grant = IDW'(idx);
            if (s1_en && !rst) req_ready[idx] = 1'b1;
         end
      end
      accept = |(req_valid & req_ready);
   end

   // pipeline registers, round-robin pointer and completion counter
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_sub   <= 1'b0;
         s1_id    <= '0;
         s2_valid <= 1'b0;
         s2_id    <= '0;
         s2_sum   <= '0;
         rr_ptr   <= '0;
         op_count <= '0;
      end else begin
         if (s2_en) begin
            s2_valid <= s1_valid;
            s2_id    <= s1_id;
            s2_sum   <= add_s;
         end
         if (s1_en) begin
            s1_valid <= accept;
            if (accept) begin
               s1_a   <= req_a[16*int'(grant) +: 16];
               s1_b   <= req_b[16*int'(grant) +: 16];
               s1_sub <= req_sub[grant];
               s1_id  <= grant;
            end
         end
         if (accept)
            rr_ptr <= (grant == IDW'(NREQ-1)) ? '0 : grant + 1'b1;
         if (s2_valid && rsp_ready)
            op_count <= op_count + 1'b1;
      end
   end

   assign rsp_valid = s2_valid;
   assign rsp_id    = s2_id;
   assign rsp_sum   = s2_sum;
   assign busy      = s1_valid | s2_valid;
endmodule

// File: tb/tb_fp16_adder_arbiter.sv
// Directed bench for fp16_adder_arbiter: expectations are queued at accept
// time and compared in order as responses are handshaken.
module tb_fp16_adder_arbiter;
   localparam int NREQ = 4;
   localparam int IDW  = 2;
   localparam int CNTW = 16;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [NREQ-1:0]    req_valid = '0;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ*16-1:0] req_a = '0;
   logic [NREQ*16-1:0] req_b = '0;
   logic [NREQ-1:0]    req_sub = '0;
   logic               rsp_valid;
   logic               rsp_ready = 1'b1;
   logic [IDW-1:0]     rsp_id;
   logic [15:0]        rsp_sum;
   logic               busy;
   logic [CNTW-1:0]    op_count;

   typedef struct packed {
      logic [IDW-1:0] id;
      logic [15:0]    sum;
   } exp_t;

   exp_t        sb[$];
   int          acc_log[$];
   logic [15:0] exp_sum [NREQ];
   int          errors = 0;
   int          checks = 0;

   fp16_adder_arbiter #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_sub(req_sub), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .busy(busy),
      .op_count(op_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b,
                          input logic sub, input logic [15:0] expv);
      req_a[16*i +: 16] = a;
      req_b[16*i +: 16] = b;
      req_sub[i]        = sub;
      req_valid[i]      = 1'b1;
      exp_sum[i]        = expv;
   endtask

   // one clock: observe handshakes at negedge, then drop accepted requests
   task automatic tick(input bit one);
      logic [NREQ-1:0] acc;
      exp_t            e;
      @(negedge clk);
      chk("rdy_at_most_one", 32'($countones(req_ready) <= 1), 32'd1);
      if (one) chk("rdy_one_hot", 32'($countones(req_ready)), 32'd1);
      acc = req_valid & req_ready;
      for (int i = 0; i < NREQ; i++) begin
         if (acc[i]) begin
            sb.push_back('{id: IDW'(i), sum: exp_sum[i]});
            acc_log.push_back(i);
         end
      end
      if (!rst && rsp_valid && rsp_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_rsp", 32'(rsp_id), 32'hFFFF_FFFF);
         end else begin
            e = sb.pop_front();
            chk("rsp_id", 32'(rsp_id), 32'(e.id));
            chk("rsp_sum", 32'(rsp_sum), 32'(e.sum));
         end
      end
      @(posedge clk);
      #1;
      req_valid = req_valid & ~acc;
   endtask

   task automatic drain();
      for (int n = 0; n < 40 && (sb.size() != 0 || busy || req_valid != 0); n++) tick(1'b0);
      chk("drain_left", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      // reset: requests are refused while rst is high
      set_req(0, 16'h3C00, 16'h3C00, 1'b0, 16'h4000);
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      tick(1'b0);
      req_valid = '0;
      tick(1'b0);
      rst = 1'b0;
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_op_count", 32'(op_count), 32'd0);
      chk("rst_rsp_id", 32'(rsp_id), 32'd0);
      chk("rst_rsp_sum", 32'(rsp_sum), 32'd0);

      // single op: 1 + 1 = 2, one-cycle latency after accept
      set_req(0, 16'h3C00, 16'h3C00, 1'b0, 16'h4000);
      tick(1'b1);
      chk("single_s1_only", 32'(rsp_valid), 32'd0);
      chk("single_busy", 32'(busy), 32'd1);
      tick(1'b0);
      chk("single_latency", 32'(rsp_valid), 32'd1);
      tick(1'b0);
      chk("single_op_count", 32'(op_count), 32'd1);
      chk("single_idle", 32'(busy), 32'd0);

      // back-to-back subtracts from req2: 2-1 = 1, 1-1 = +0
      set_req(2, 16'h4000, 16'h3C00, 1'b1, 16'h3C00);
      tick(1'b1);
      set_req(2, 16'h3C00, 16'h3C00, 1'b1, 16'h0000);
      tick(1'b1);
      chk("b2b_first", 32'(rsp_valid), 32'd1);
      tick(1'b0);
      chk("b2b_second", 32'(rsp_valid), 32'd1);
      tick(1'b0);
      chk("b2b_done", 32'(rsp_valid), 32'd0);

      // NaN operand from req1
      set_req(1, 16'h7E00, 16'h3C00, 1'b0, 16'hFE00);
      drain();
      // req3: -2 + 2 gives +0, and leaves rr_ptr at 0
      set_req(3, 16'hC000, 16'h4000, 1'b0, 16'h0000);
      drain();

      // two waves of full contention, each granted 0,1,2,3
      for (int w = 0; w < 2; w++) begin
         acc_log.delete();
         set_req(0, 16'h3C00, 16'h4000, 1'b0, 16'h4200);
         set_req(1, 16'h4000, 16'h4000, 1'b0, 16'h4400);
         set_req(2, 16'h3800, 16'h3800, 1'b0, 16'h3C00);
         set_req(3, 16'h4400, 16'h3C00, 1'b1, 16'h4200);
         for (int k = 0; k < 4; k++) begin
            tick(1'b1);
            if (k >= 1) chk("rr_rsp_stream", 32'(rsp_valid), 32'd1);
         end
         tick(1'b0);
         chk("rr_rsp_last", 32'(rsp_valid), 32'd1);
         chk("rr_grant_count", 32'(acc_log.size()), 32'd4);
         for (int k = 0; k < 4 && k < acc_log.size(); k++)
            chk("rr_grant_order", 32'(acc_log[k]), 32'(k));
         drain();
      end

      // backpressure: only two ops fit while rsp_ready is low
      rst = 1'b1;
      tick(1'b0);
      rst = 1'b0;
      acc_log.delete();
      rsp_ready = 1'b0;
      set_req(0, 16'h3C00, 16'h3C00, 1'b0, 16'h4000);
      set_req(1, 16'h4200, 16'h3C00, 1'b0, 16'h4400);
      set_req(2, 16'h4400, 16'h4000, 1'b1, 16'h4000);
      for (int k = 0; k < 4; k++) tick(1'b0);
      #1;
      chk("bp_accepted", 32'(acc_log.size()), 32'd2);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_rsp_held", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_id_held", 32'(rsp_id), 32'd0);
      chk("bp_op_count", 32'(op_count), 32'd0);
      rsp_ready = 1'b1;
      drain();
      for (int k = 0; k < 3; k++) tick(1'b0);
      chk("bp_total", 32'(acc_log.size()), 32'd3);
      chk("bp_op_count_done", 32'(op_count), 32'd3);

      // reset with two ops in flight: no response survives
      set_req(0, 16'h3C00, 16'h3C00, 1'b0, 16'h4000);
      set_req(1, 16'h3C00, 16'h3C00, 1'b0, 16'h4000);
      tick(1'b1);
      tick(1'b1);
      chk("mid_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      tick(1'b0);
      rst = 1'b0;
      sb.delete();
      chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("mid_busy_clr", 32'(busy), 32'd0);
      chk("mid_op_count", 32'(op_count), 32'd0);
      // rr_ptr back at 0: req0 wins over req3
      set_req(3, 16'h4000, 16'h4000, 1'b0, 16'h4400);
      set_req(0, 16'h3800, 16'h3C00, 1'b0, 16'h3E00);
      #1;
      chk("mid_rr_ptr", 32'(req_ready), 32'd1);
      drain();
      for (int k = 0; k < 3; k++) tick(1'b0);
      chk("mid_op_count_after", 32'(op_count), 32'd2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
